// File: rtl/joypad_input_conditioner_if.sv
// joypad_input_conditioner_if: button bus between board pins and the conditioner.
// master drives raw levels and controls; slave returns the conditioned levels.
interface joypad_input_conditioner_if #(
  parameter int NBTN = 8
);
  logic [NBTN-1:0] btn_raw;
  logic            gate;
  logic [1:0]      socd_mode;
  logic [NBTN-1:0] turbo_mask;
  logic [NBTN-1:0] combo_mask;
  logic [NBTN-1:0] btn_clean;
  logic [NBTN-1:0] btn_out;
  logic [NBTN-1:0] press_evt;
  logic [NBTN-1:0] release_evt;
  logic            combo_fire;

  modport master (
    output btn_raw,
    output gate,
    output socd_mode,
    output turbo_mask,
    output combo_mask,
    input  btn_clean,
    input  btn_out,
    input  press_evt,
    input  release_evt,
    input  combo_fire
  );

  modport slave (
    input  btn_raw,
    input  gate,
    input  socd_mode,
    input  turbo_mask,
    input  combo_mask,
    output btn_clean,
    output btn_out,
    output press_evt,
    output release_evt,
    output combo_fire
  );
endinterface

// File: rtl/joypad_input_conditioner.sv
// joypad_input_conditioner: sync, debounce, gate, SOCD, turbo, combo detect.
// Turbo prescaler/phase exist only when JOY_TURBO_EN is defined.
module joypad_input_conditioner #(
  parameter int NBTN       = 8,
  parameter int DEB_LEN    = 15,
  parameter int CW         = 24,
  parameter int COMBO_HOLD = 1000000,
  parameter int TURBO_DIV  = 18
) (
  input logic                       pclk,
  input logic                       reset_n,
  joypad_input_conditioner_if.slave jp
);

  localparam logic [7:0]    DEB_MAX = 8'(DEB_LEN - 1);
  localparam logic [CW-1:0] HOLD    = CW'(COMBO_HOLD);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  // history: bit1 = high member (DOWN/LEFT), bit0 = low member (UP/RIGHT)
  function automatic logic [1:0] hist_upd(
    input logic [1:0] h,
    input logic [1:0] pe
  );
    logic [1:0] r;
    if (&pe)       r = 2'b00;
    else if (pe[1]) r = 2'b10;
    else if (pe[0]) r = 2'b01;
    else           r = h;
    return r;
  endfunction

  function automatic logic [1:0] neutral(input logic [1:0] p);
    return (&p) ? 2'b00 : p;
  endfunction

  function automatic logic [1:0] last_wins(
    input logic [1:0] p,
    input logic [1:0] h
  );
    return (&p) ? h : p;
  endfunction

  logic [NBTN-1:0] meta_q;
  logic [NBTN-1:0] sync_q;
  logic [NBTN-1:0] deb_in;
  logic [7:0]      cnt_q [NBTN];
  logic [7:0]      cnt_d [NBTN];
  logic [NBTN-1:0] clean_q;
  logic [NBTN-1:0] clean_d;
  logic [NBTN-1:0] press_q;
  logic [NBTN-1:0] release_q;

  logic [1:0]      vhist_q;
  logic [1:0]      vhist_d;
  logic [1:0]      hhist_q;
  logic [1:0]      hhist_d;
  logic [NBTN-1:0] socd_q;
  logic [NBTN-1:0] socd_d;
  logic [1:0]      vn;
  logic [1:0]      hn;
  logic [1:0]      vb;
  logic [1:0]      hb;
  logic [NBTN-1:0] out_q;

  logic [NBTN-1:0] cmask_q;
  logic [CW-1:0]   ccnt_q;
  logic [CW-1:0]   ccnt_d;
  logic            chit;
  logic            cfire_q;
  logic            cfire_d;

  // two-flop synchroniser for the asynchronous pins
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= jp.btn_raw;
      sync_q <= meta_q;
    end
  end

  assign deb_in = sync_q & {NBTN{jp.gate}};

  // per-bit run-length debounce; same rule for press and release
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < NBTN; i++) begin
      cnt_d[i] = 8'd0;
      if (deb_in[i] != clean_q[i]) begin
        if (cnt_q[i] == DEB_MAX) clean_d[i] = deb_in[i];
        else cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // debounced level, counters and edge pulses
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      clean_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NBTN; i++) cnt_q[i] <= 8'd0;
    end else begin
      clean_q   <= clean_d;
      press_q   <= clean_d & ~clean_q;
      release_q <= ~clean_d & clean_q;
      for (int i = 0; i < NBTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // newest press per axis; updated every mode so switching keeps history
  always_comb begin
    vhist_d = hist_upd(vhist_q, press_q[7:6]);
    hhist_d = hist_upd(hhist_q, press_q[5:4]);
  end

  // SOCD resolution of the D-pad; face buttons pass through
  always_comb begin
    socd_d = clean_q;
    vn     = neutral(clean_q[7:6]);
    hn     = neutral(clean_q[5:4]);
    vb     = 2'b00;
    hb     = 2'b00;
    unique case (jp.socd_mode)
      2'b00: socd_d = clean_q;
      2'b01: socd_d[7:4] = {vn, hn};
      2'b10: begin
        socd_d[7:6] = last_wins(clean_q[7:6], vhist_d);
        socd_d[5:4] = last_wins(clean_q[5:4], hhist_d);
      end
      2'b11: begin
        // held axis keeps priority; vertical wins a tie from idle
        vb = (|socd_q[5:4]) ? 2'b00 : vn;
        hb = ((|socd_q[7:6]) || (|vb)) ? 2'b00 : hn;
        socd_d[7:4] = {vb, hb};
      end
    endcase
  end

  // SOCD output and last-wins history registers
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      socd_q  <= '0;
      vhist_q <= 2'b00;
      hhist_q <= 2'b00;
    end else begin
      socd_q  <= socd_d;
      vhist_q <= vhist_d;
      hhist_q <= hhist_d;
    end
  end

`ifdef JOY_TURBO_EN
  localparam logic [TURBO_DIV-1:0] P_ONE = TURBO_DIV'(1);

  logic [TURBO_DIV-1:0] pre_q;
  logic                 phase_q;

  // free-running prescaler; a turbo press restarts it in the on phase
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      phase_q <= 1'b1;
    end else if (|(press_q & jp.turbo_mask)) begin
      pre_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      pre_q <= pre_q + P_ONE;
      if (&pre_q) phase_q <= ~phase_q;
    end
  end

  // final output: turbo-masked bits chopped by the phase
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) out_q <= '0;
    else out_q <= socd_q & (~jp.turbo_mask | {NBTN{phase_q}});
  end
`else
  logic unused_turbo;
  assign unused_turbo = ^{jp.turbo_mask, TURBO_DIV[0]};

  // final output: SOCD level delayed once so latency matches turbo build
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) out_q <= '0;
    else out_q <= socd_q;
  end
`endif

  // combo hit on ungated bits; counter saturates, fires once on arrival
  always_comb begin
    chit    = (|jp.combo_mask) &&
              ((sync_q & jp.combo_mask) == jp.combo_mask);
    ccnt_d  = ccnt_q;
    cfire_d = 1'b0;
    if (!chit || (jp.combo_mask != cmask_q)) begin
      ccnt_d = '0;
    end else if (ccnt_q != HOLD) begin
      ccnt_d  = ccnt_q + C_ONE;
      cfire_d = (ccnt_d == HOLD);
    end
  end

  // combo counter, mask history and fire pulse
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      ccnt_q  <= '0;
      cmask_q <= '0;
      cfire_q <= 1'b0;
    end else begin
      ccnt_q  <= ccnt_d;
      cmask_q <= jp.combo_mask;
      cfire_q <= cfire_d;
    end
  end

  assign jp.btn_clean   = clean_q;
  assign jp.btn_out     = out_q;
  assign jp.press_evt   = press_q;
  assign jp.release_evt = release_q;
  assign jp.combo_fire  = cfire_q;

endmodule

// File: tb/tb_joypad_input_conditioner.sv
// tb_joypad_input_conditioner: directed vectors, queued expectations.
// Level checks are due on a cycle; combo pulses are matched by a monitor.
module tb_joypad_input_conditioner;

  localparam int NBTN = 8;

  typedef struct {
    int         due;
    int         id;
    int         step;
    logic [7:0] mask;
    logic [7:0] exp;
  } chk_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   step  = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   c;
  int   c2;
  bit   final_req  = 1'b0;
  bit   final_done = 1'b0;

  chk_t exp_q[$];
  int   combo_q[$];
  chk_t mon_e;
  int   mon_d;
  logic [7:0] mon_a;

  joypad_input_conditioner_if #(.NBTN(NBTN)) jp();

  joypad_input_conditioner #(
    .NBTN(NBTN),
    .DEB_LEN(15),
    .CW(24),
    .COMBO_HOLD(1000),
    .TURBO_DIV(4)
  ) dut (
    .pclk(clk),
    .reset_n(rst_n),
    .jp(jp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] act(input int id);
    case (id)
      0: return jp.btn_clean;
      1: return jp.btn_out;
      2: return jp.press_evt;
      3: return jp.release_evt;
      default: return {7'd0, jp.combo_fire};
    endcase
  endfunction

  function automatic string nm(input int id);
    case (id)
      0: return "btn_clean";
      1: return "btn_out";
      2: return "press_evt";
      3: return "release_evt";
      default: return "combo_fire";
    endcase
  endfunction

  task automatic expect_at(input int due, input int id,
                           input logic [7:0] mask,
                           input logic [7:0] exp);
    chk_t e;
    int   k;
    e.due  = due;
    e.id   = id;
    e.step = step;
    e.mask = mask;
    e.exp  = exp & mask;
    k = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].due > due) begin
        k = i;
        break;
      end
    end
    exp_q.insert(k, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_raw(input logic [7:0] v, output int cc);
    @(negedge clk);
    jp.btn_raw = v;
    cc = cyc;
  endtask

  // scoreboard monitor: due level checks and combo pulse matching
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      mon_a = act(mon_e.id) & mon_e.mask;
      n_chk++;
      if (mon_e.due != cyc || mon_a != mon_e.exp) begin
        n_fail++;
        $display("FAIL step%0d %s cyc=%0d due=%0d got=%02h exp=%02h",
                 mon_e.step, nm(mon_e.id), cyc, mon_e.due,
                 mon_a, mon_e.exp);
      end
    end
    if (jp.combo_fire === 1'b1) begin
      n_chk++;
      if (combo_q.size() == 0) begin
        n_fail++;
        $display("FAIL step%0d combo_fire unexpected pulse cyc=%0d",
                 step, cyc);
      end else begin
        mon_d = combo_q.pop_front();
        if (mon_d != cyc) begin
          n_fail++;
          $display("FAIL step%0d combo_fire cyc=%0d exp=%0d",
                   step, cyc, mon_d);
        end
      end
    end
    if (final_req && !final_done) begin
      final_done = 1'b1;
      n_chk++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL level_queue left=%0d exp=0", exp_q.size());
      end
      n_chk++;
      if (combo_q.size() != 0) begin
        n_fail++;
        $display("FAIL combo_queue missing=%0d exp=0", combo_q.size());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    jp.btn_raw    = 8'h00;
    jp.gate       = 1'b1;
    jp.socd_mode  = 2'b00;
    jp.turbo_mask = 8'h00;
    jp.combo_mask = 8'h0F;

    // reset state
    for (int id = 0; id < 5; id++) expect_at(2, id, 8'hFF, 8'h00);
    tick(4);
    rst_n = 1'b1;
    tick(3);

    // press A: clean at +17, one press pulse, btn_out at +19
    step = 1;
    drive_raw(8'h01, c);
    expect_at(c + 16, 0, 8'h01, 8'h00);
    expect_at(c + 17, 0, 8'h01, 8'h01);
    expect_at(c + 16, 2, 8'h01, 8'h00);
    expect_at(c + 17, 2, 8'h01, 8'h01);
    expect_at(c + 18, 2, 8'h01, 8'h00);
    expect_at(c + 18, 1, 8'h01, 8'h00);
    expect_at(c + 19, 1, 8'h01, 8'h01);
    tick(30);

    // release A: symmetric latency
    step = 2;
    drive_raw(8'h00, c);
    expect_at(c + 16, 0, 8'h01, 8'h01);
    expect_at(c + 17, 0, 8'h01, 8'h00);
    expect_at(c + 17, 3, 8'h01, 8'h01);
    expect_at(c + 18, 1, 8'h01, 8'h01);
    expect_at(c + 19, 1, 8'h01, 8'h00);
    tick(30);

    // 10-cycle glitch rejected
    step = 3;
    drive_raw(8'h01, c);
    tick(9);
    drive_raw(8'h00, c2);
    expect_at(c + 17, 0, 8'h01, 8'h00);
    expect_at(c + 17, 2, 8'h01, 8'h00);
    expect_at(c + 30, 0, 8'h01, 8'h00);
    tick(30);

    // gate drop releases after debounce, gate return presses again
    step = 4;
    drive_raw(8'h02, c);
    expect_at(c + 17, 0, 8'h02, 8'h02);
    tick(25);
    @(negedge clk);
    jp.gate = 1'b0;
    c = cyc;
    expect_at(c + 14, 0, 8'h02, 8'h02);
    expect_at(c + 15, 0, 8'h02, 8'h00);
    expect_at(c + 15, 3, 8'h02, 8'h02);
    tick(25);
    @(negedge clk);
    jp.gate = 1'b1;
    c = cyc;
    expect_at(c + 14, 0, 8'h02, 8'h00);
    expect_at(c + 15, 0, 8'h02, 8'h02);
    tick(25);
    drive_raw(8'h00, c);
    expect_at(c + 17, 0, 8'h02, 8'h00);
    tick(25);

    // mode 01: LEFT+RIGHT neutral, release RIGHT gives LEFT
    step = 5;
    @(negedge clk);
    jp.socd_mode = 2'b01;
    drive_raw(8'h30, c);
    expect_at(c + 17, 0, 8'h30, 8'h30);
    expect_at(c + 19, 1, 8'h30, 8'h00);
    expect_at(c + 25, 1, 8'h30, 8'h00);
    tick(30);
    drive_raw(8'h20, c);
    expect_at(c + 18, 1, 8'h30, 8'h00);
    expect_at(c + 19, 1, 8'h30, 8'h20);
    tick(25);
    drive_raw(8'h00, c);
    tick(25);

    // mode 10: newest press wins, release returns to the other
    step = 6;
    @(negedge clk);
    jp.socd_mode = 2'b10;
    drive_raw(8'h20, c);
    expect_at(c + 19, 1, 8'h30, 8'h20);
    tick(99);
    drive_raw(8'h30, c);
    expect_at(c + 18, 1, 8'h30, 8'h20);
    expect_at(c + 19, 1, 8'h30, 8'h10);
    tick(25);
    drive_raw(8'h20, c);
    expect_at(c + 18, 1, 8'h30, 8'h10);
    expect_at(c + 19, 1, 8'h30, 8'h20);
    tick(25);
    drive_raw(8'h00, c);
    tick(25);

    // mode 10 same-cycle press: neutral until LEFT released
    step = 7;
    drive_raw(8'h30, c);
    expect_at(c + 17, 0, 8'h30, 8'h30);
    expect_at(c + 19, 1, 8'h30, 8'h00);
    expect_at(c + 30, 1, 8'h30, 8'h00);
    tick(35);
    drive_raw(8'h10, c);
    expect_at(c + 19, 1, 8'h30, 8'h10);
    tick(25);
    drive_raw(8'h00, c);
    tick(25);

    // mode 11: held UP blocks RIGHT until released
    step = 8;
    @(negedge clk);
    jp.socd_mode = 2'b11;
    drive_raw(8'h40, c);
    expect_at(c + 19, 1, 8'h50, 8'h40);
    tick(29);
    drive_raw(8'h50, c);
    expect_at(c + 25, 0, 8'h50, 8'h50);
    expect_at(c + 25, 1, 8'h50, 8'h40);
    tick(30);
    drive_raw(8'h10, c);
    expect_at(c + 19, 1, 8'h50, 8'h00);
    expect_at(c + 20, 1, 8'h50, 8'h10);
    tick(25);
    drive_raw(8'h00, c);
    tick(25);

    // mode 11: both axes from idle, vertical wins
    step = 9;
    drive_raw(8'h50, c);
    expect_at(c + 19, 1, 8'h50, 8'h40);
    expect_at(c + 30, 1, 8'h50, 8'h40);
    tick(35);
    drive_raw(8'h00, c);
    tick(25);

    // combo: single pulse, no refire while held, fires again on re-hold
    step = 10;
    drive_raw(8'h0F, c);
    combo_q.push_back(c + 1002);
    tick(1300);
    drive_raw(8'h00, c);
    tick(20);
    drive_raw(8'h0F, c);
    combo_q.push_back(c + 1002);
    tick(1100);
    drive_raw(8'h00, c);
    tick(20);

    // combo_mask 0 disables; restoring it restarts the count
    step = 11;
    @(negedge clk);
    jp.combo_mask = 8'h00;
    drive_raw(8'h0F, c);
    tick(1100);
    @(negedge clk);
    jp.combo_mask = 8'h0F;
    c = cyc;
    combo_q.push_back(c + 1001);
    tick(1050);
    drive_raw(8'h00, c);
    tick(20);

    // mask change mid-count clears the counter
    step = 12;
    drive_raw(8'h0F, c);
    tick(499);
    @(negedge clk);
    jp.combo_mask = 8'h07;
    c2 = cyc;
    combo_q.push_back(c2 + 1001);
    tick(1050);
    drive_raw(8'h00, c);
    jp.combo_mask = 8'h0F;
    tick(25);

    // turbo on A, then asynchronous reset mid-pattern
    step = 13;
    @(negedge clk);
    jp.turbo_mask = 8'h01;
    drive_raw(8'h01, c);
`ifdef JOY_TURBO_EN
    expect_at(c + 18, 1, 8'h01, 8'h00);
    expect_at(c + 19, 1, 8'h01, 8'h01);
    expect_at(c + 34, 1, 8'h01, 8'h01);
    expect_at(c + 35, 1, 8'h01, 8'h00);
    expect_at(c + 50, 1, 8'h01, 8'h00);
    expect_at(c + 51, 1, 8'h01, 8'h01);
`else
    expect_at(c + 19, 1, 8'h01, 8'h01);
    expect_at(c + 35, 1, 8'h01, 8'h01);
    expect_at(c + 51, 1, 8'h01, 8'h01);
`endif
    tick(55);
    step = 14;
    expect_at(c + 55, 0, 8'h01, 8'h01);
    @(posedge clk);
    #2;
    for (int id = 0; id < 5; id++) expect_at(cyc, id, 8'hFF, 8'h00);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    drive_raw(8'h00, c);
    tick(30);

    final_req = 1'b1;
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
